// File: rtl/sram_ctrl.sv
// sram_ctrl: single-outstanding load/store initiator for gac_sram; registered non-overlapping strobes, RMW for sub-word stores.
// Latency: load ACCESS_CYC+1, word store ACCESS_CYC+3, sub-word store 2*ACCESS_CYC+3, error 1; req_ready held low while busy.
module sram_ctrl #(
   parameter int ACCESS_CYC = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        sram_cs,
   output logic        sram_oe,
   output logic        sram_we,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_din,
   input  logic [31:0] sram_dout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WS,
      S_WR,
      S_WREC,
      S_RESP,
      S_ERR
   } state_t;

   localparam logic [3:0] CTR_LAST = 4'(ACCESS_CYC - 1);

   state_t      state_q, state_d;
   logic [3:0]  ctr_q, ctr_d;
   logic        we_q;
   logic [1:0]  size_q;
   logic [1:0]  lane_q;
   logic [31:0] wdata_q;

   logic        accept;
   logic        req_err;
   logic        rd_last;
   logic        cs_d, oe_d, we_d, ready_d, rvalid_d, rerr_d;

   assign accept  = req_valid & req_ready & (state_q == S_IDLE);
   assign req_err = (req_size == 2'b11) ||
                    ((req_size == 2'b01) && req_addr[0]) ||
                    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
   assign rd_last = (state_q == S_RD) && (ctr_q == CTR_LAST);

   // Replace the addressed byte/half lanes of the read word with store data.
   function automatic logic [31:0] merge_word(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] lane);
      logic [31:0] mask;
      logic [31:0] data;
      if (size == 2'b00) begin
         mask = 32'h0000_00FF << {lane, 3'b000};
         data = {24'b0, wdata[7:0]} << {lane, 3'b000};
      end else begin
         mask = 32'h0000_FFFF << {lane[1], 4'b0000};
         data = {16'b0, wdata[15:0]} << {lane[1], 4'b0000};
      end
      return (word & ~mask) | (data & mask);
   endfunction

   function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] lane);
      logic [31:0] res;
      case (size)
         2'b00:   res = {24'b0, 8'(word >> {lane, 3'b000})};
         2'b01:   res = {16'b0, 16'(word >> {lane[1], 4'b0000})};
         default: res = word;
      endcase
      return res;
   endfunction

   always_comb begin
      state_d = state_q;
      ctr_d   = ctr_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               ctr_d = 4'd0;
               if (req_err)
                  state_d = S_ERR;
               else if (!req_we || (req_size != 2'b10))
                  state_d = S_RD;
               else
                  state_d = S_WS;
            end
         end
         S_RD: begin
            if (ctr_q == CTR_LAST) begin
               ctr_d   = 4'd0;
               state_d = we_q ? S_WS : S_RESP;
            end else begin
               ctr_d = ctr_q + 4'd1;
            end
         end
         S_WS: begin
            ctr_d   = 4'd0;
            state_d = S_WR;
         end
         S_WR: begin
            if (ctr_q == CTR_LAST)
               state_d = S_WREC;
            else
               ctr_d = ctr_q + 4'd1;
         end
         S_WREC:  state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the flops line up with state_q.
   always_comb begin
      cs_d     = (state_d == S_RD) || (state_d == S_WS) || (state_d == S_WR);
      oe_d     = (state_d == S_RD);
      we_d     = (state_d == S_WR);
      ready_d  = (state_d == S_IDLE);
      rvalid_d = (state_d == S_RESP) || (state_d == S_ERR);
      rerr_d   = (state_d == S_ERR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ctr_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         ctr_q   <= ctr_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'd0;
         sram_cs    <= 1'b0;
         sram_oe    <= 1'b0;
         sram_we    <= 1'b0;
         sram_addr  <= 32'd0;
         sram_din   <= 32'd0;
         we_q       <= 1'b0;
         size_q     <= 2'b00;
         lane_q     <= 2'b00;
         wdata_q    <= 32'd0;
      end else begin
         req_ready  <= ready_d;
         resp_valid <= rvalid_d;
         resp_err   <= rerr_d;
         sram_cs    <= cs_d;
         sram_oe    <= oe_d;
         sram_we    <= we_d;
         resp_rdata <= 32'd0;
         if (accept) begin
            we_q    <= req_we;
            size_q  <= req_size;
            lane_q  <= req_addr[1:0];
            wdata_q <= req_wdata;
            if (!req_err) begin
               sram_addr <= {req_addr[31:2], 2'b00};
               if (req_we && (req_size == 2'b10))
                  sram_din <= req_wdata;
            end
         end
         if (rd_last) begin
            if (we_q)
               sram_din <= merge_word(sram_dout, wdata_q, size_q, lane_q);
            else
               resp_rdata <= extract(sram_dout, size_q, lane_q);
         end
      end
   end

endmodule
